game_ctrl: RTL
==============

Name: game_ctrl

Overview:
- Round/level sequencer for the hit-or-miss game.
- Drives the frequency generator's enable and difficulty inputs.
- Consumes the one-cycle hit/miss pulses from the hit detector and keeps score, lives and level.
- Handles start, pause, the inter-level gap and game-over; sits between the player buttons and the freq/hit datapath.

Parameters:
ROUNDS_PER_LEVEL, 8, scored events (hit or miss) per level before difficulty advances; range 1..255
START_LIVES, 3, lives loaded at game start; range 1..3
MAX_LEVEL, 7, highest difficulty code; range 0..7
GAP_CYCLES, 25000000, clk cycles with enable low between levels; must be >=1
SCORE_W, 10, score width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, debounced upstream
pause  in  1  one-cycle pulse, debounced upstream; toggles pause
hit  in  1  one-cycle pulse from hit detector
miss  in  1  one-cycle pulse from hit detector
enable  out  1  enable to frequency generator
difficulty  out  3  difficulty code to frequency generator
score  out  SCORE_W  hits this game
lives  out  2  remaining lives
level_up  out  1  one-cycle pulse when difficulty increments
game_over  out  1  high while in OVER
state  out  3  encoded FSM state, for debug/display: IDLE=0, PLAY=1, PAUSE=2, GAP=3, OVER=4

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, enable=0, difficulty=0, score=0, lives=START_LIVES, level_up=0, game_over=0, round counter=0, gap counter=0. Released synchronously; takes effect at any point, including mid-game.
- All outputs are registered; every state change is visible on the cycle after the causing input.
- IDLE:
  - enable=0.
  - start -> PLAY; score=0, lives=START_LIVES, difficulty=0, round=0 loaded on the same edge.
  - All other inputs ignored.
- PLAY:
  - enable=1.
  - Events are evaluated each cycle in this priority order:
    - hit&miss same cycle: treated as miss only.
    - miss: lives-1, round+1. If lives was 1 -> lives=0, go OVER; level/pause logic suppressed that cycle.
    - hit: score+1, saturating at all-ones; round+1.
    - Round completion: when an event brings round to ROUNDS_PER_LEVEL, round=0.
      - If difficulty<MAX_LEVEL: difficulty+1, level_up=1 for exactly one cycle, go GAP, gap counter=0.
      - Else: stay in PLAY; difficulty holds, no level_up.
    - pause, with no game-ending miss that cycle: go PAUSE. Any hit/miss/round completion in the same cycle is still applied first. If a level transition also fires, GAP wins and pause is dropped.
  - start ignored.
- PAUSE:
  - enable=0; hit/miss/start ignored; counters frozen.
  - pause -> PLAY.
- GAP:
  - enable=0; hit/miss/pause/start ignored.
  - Gap counter increments every cycle. On the cycle the count reaches GAP_CYCLES-1 -> PLAY, so enable is low for exactly GAP_CYCLES cycles.
- OVER:
  - game_over=1, enable=0; score, difficulty and lives (0) held for display.
  - start -> IDLE (game_over drops next cycle). A second start is needed to play.
- Width rules:
  - Round counter is 8 bits.
  - Lives never underflows; a miss with lives=0 is impossible, since OVER is entered at 0.
  - Difficulty never exceeds MAX_LEVEL.
- level_up is high only on the PLAY->GAP transition cycle; it is 0 in every other state.

Test Plan (bench uses ROUNDS_PER_LEVEL=4, GAP_CYCLES=10, START_LIVES=3, MAX_LEVEL=2):
1. Reset then start pulse -> next cycle state=PLAY, enable=1, score=0, lives=3, difficulty=0; start while in PLAY has no effect.
2. 4 hit pulses -> score=4, level_up high exactly 1 cycle, difficulty=1, enable low exactly 10 cycles, then PLAY; hits during GAP leave score=4.
3. 3 misses at difficulty 0 -> lives 2,1,0, state=OVER, game_over=1, enable=0, score held; start -> IDLE; start again -> PLAY with score=0, lives=3.
4. hit and miss in same cycle -> lives-1, score unchanged, round+1. Pause pulse -> enable=0, hits ignored. Second pause -> PLAY, enable=1.
5. Advance to difficulty=2 (MAX_LEVEL), then 4 more hits -> difficulty stays 2, no level_up, no GAP, state stays PLAY.
6. Assert rst low mid-GAP, asynchronously between clk edges -> outputs return to reset values immediately. After release, state=IDLE until start.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: round/level sequencer for the hit-or-miss game.
// Drives the frequency generator (enable, difficulty) and consumes hit/miss
// pulses from the hit detector to keep score, lives and level.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      one-cycle start pulse (debounced upstream)
//   pause      one-cycle pause toggle pulse (debounced upstream)
//   hit, miss  one-cycle pulses from the hit detector
//   enable     enable to frequency generator
//   difficulty difficulty code to frequency generator
//   score      hits this game (saturating)
//   lives      remaining lives
//   level_up   one-cycle pulse when difficulty increments
//   game_over  high while in OVER
//   state      encoded state: IDLE=0, PLAY=1, PAUSE=2, GAP=3, OVER=4
module game_ctrl #(
  parameter int unsigned ROUNDS_PER_LEVEL = 8,
  parameter int unsigned START_LIVES      = 3,
  parameter int unsigned MAX_LEVEL        = 7,
  parameter int unsigned GAP_CYCLES       = 25000000,
  parameter int unsigned SCORE_W          = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               hit,
  input  logic               miss,
  output logic               enable,
  output logic [2:0]         difficulty,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               level_up,
  output logic               game_over,
  output logic [2:0]         state
);

  // Gap counter only needs to hold 0..GAP_CYCLES-1.
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_GAP   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           st;
  logic [7:0]       round_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic [7:0] round_inc;
  logic       event_c;
  logic       fatal_c;
  logic       round_done_c;
  logic       lvl_adv_c;

  // PLAY-state event decode: a miss on the last life ends the game and
  // suppresses level/pause handling; a completed round advances the level
  // only while below the top difficulty.
  always_comb begin
    round_inc    = round_cnt + 8'd1;
    event_c      = hit | miss;
    fatal_c      = miss && (lives == 2'd1);
    round_done_c = event_c && (round_inc == 8'(ROUNDS_PER_LEVEL));
    lvl_adv_c    = round_done_c && !fatal_c && (difficulty < 3'(MAX_LEVEL));
  end

  assign state = st;

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= S_IDLE;
      enable     <= 1'b0;
      difficulty <= 3'd0;
      score      <= '0;
      lives      <= 2'(START_LIVES);
      level_up   <= 1'b0;
      game_over  <= 1'b0;
      round_cnt  <= 8'd0;
      gap_cnt    <= '0;
    end else begin
      level_up <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start) begin
            st         <= S_PLAY;
            enable     <= 1'b1;
            score      <= '0;
            lives      <= 2'(START_LIVES);
            difficulty <= 3'd0;
            round_cnt  <= 8'd0;
          end
        end

        S_PLAY: begin
          // A simultaneous hit and miss counts as a miss only.
          if (miss) begin
            if (fatal_c) begin
              lives     <= 2'd0;
              st        <= S_OVER;
              enable    <= 1'b0;
              game_over <= 1'b1;
            end else begin
              lives <= lives - 2'd1;
            end
          end else if (hit && (score != {SCORE_W{1'b1}})) begin
            score <= score + SCORE_W'(1);
          end

          if (!fatal_c) begin
            if (round_done_c) begin
              round_cnt <= 8'd0;
              if (lvl_adv_c) begin
                difficulty <= difficulty + 3'd1;
                level_up   <= 1'b1;
                st         <= S_GAP;
                gap_cnt    <= '0;
                enable     <= 1'b0;
              end
            end else if (event_c) begin
              round_cnt <= round_inc;
            end

            // Level transition takes precedence over a same-cycle pause.
            if (pause && !lvl_adv_c) begin
              st     <= S_PAUSE;
              enable <= 1'b0;
            end
          end
        end

        S_PAUSE: begin
          if (pause) begin
            st     <= S_PLAY;
            enable <= 1'b1;
          end
        end

        S_GAP: begin
          // Entry edge plus GAP_CYCLES-1 counted cycles keeps enable low
          // for exactly GAP_CYCLES cycles.
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            st     <= S_PLAY;
            enable <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_OVER: begin
          if (start) begin
            st        <= S_IDLE;
            game_over <= 1'b0;
          end
        end

        default: begin
          st        <= S_IDLE;
          enable    <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule
